fp_div_operand_stage: RTL and testbench
=======================================

Name: fp_div_operand_stage

Overview:
- Upstream issue stage for the combinational FP32 divider.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Classifies IEEE-754 special cases and presents one registered operand pair to the divider.
- When a special case applies, it also presents a ready-made substitute result; downstream muxes this in place of the divider output.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating special-case counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  stage can accept a pair this cycle.
- in_a  input  32  FP32 dividend.
- in_b  input  32  FP32 divisor.
- div_valid  output  1  registered pair valid toward the divider.
- div_ready  input  1  downstream consumes the pair this cycle.
- div_a  output  32  registered dividend to the divider.
- div_b  output  32  registered divisor to the divider.
- div_special  output  1  use div_special_result instead of the divider output.
- div_special_result  output  32  substitute FP32 result.
- special_count  output  CNT_W  saturating count of special pairs issued.

Behaviour:
- Reset (rst high at an edge): FIFO empty with pointers at 0; div_valid=0; div_a=0; div_b=0; div_special=0; div_special_result=0; special_count=0.
- in_ready is forced to 0 while rst is high.
- Reset mid-operation discards all buffered and presented pairs; nothing is replayed.
- in_ready = (count < DEPTH). It depends only on registered count, with no combinational path from div_ready.
- Push occurs when in_valid && in_ready.
- Output register loads from the FIFO head when the FIFO is non-empty and (!div_valid || div_ready). That cycle is a pop.
- Otherwise, div_valid clears after a handshake (div_valid && div_ready) with an empty FIFO, and holds all outputs stable while div_valid && !div_ready.
- Push and pop may occur in the same cycle; count is unchanged in that case.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Latency: a pair accepted at edge N with the stage idle shows div_valid=1 from edge N+1 to N+2, i.e. two edges after acceptance. There is no FIFO bypass.
- Throughput: one pair per cycle while div_ready=1.
- Capacity: DEPTH+1 pairs (FIFO plus output register).
- Order is strictly FIFO.
- Classification is combinational on the FIFO head and registered with it.
- Input fields: exponent field e and fraction f. Zero means e==0, so denormals flush to zero. Inf means e==255 and f==0. NaN means e==255 and f!=0.
- Result sign s = a[31]^b[31].
- Special-case priority, first match wins:
  1. a or b is NaN → 0x7FC00000.
  2. inf/inf or zero/zero → 0x7FC00000.
  3. a is inf or b is zero → {s, 8'hFF, 23'h0}.
  4. a is zero or b is inf → {s, 31'h0}.
  5. Otherwise div_special=0 and div_special_result=0.
- div_a and div_b always carry the raw operands, including for special pairs.
- special_count increments by 1 on each handshake with div_special=1 and saturates at all-ones.
- Protocol rule: upstream must hold in_a and in_b stable while in_valid && !in_ready.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_MAX=8'hFF, FP32_BIAS=127;
  - field-extract functions;
  - an fp32_class_t enum {ZERO, NORMAL, INF, NAN}.
- One sub-module, fp32_classify: purely combinational, 32-bit input → fp32_class_t. Instantiated twice, on head a and head b.
- The FIFO stays inline.

Test Plan:
- Normal pair: in_a=0x40C00000, in_b=0x40000000, div_ready=1, idle stage → div_valid high two edges after acceptance, div_a/div_b equal to inputs, div_special=0, special_count=0.
- Division by zero: 0x3F800000 / 0x00000000 → div_special=1, result 0x7F800000. Then 0xBF800000 / 0x00000000 → 0xFF800000. special_count=2.
- Invalid operations: 0/0, 0x7F800000/0xFF800000, and 0x7FC00001/0x3F800000 → each gives result 0x7FC00000. Denormal 0x00000001/0x3F800000 → 0x00000000.
- Backpressure: div_ready=0, push 0x3F800000/k for k=1..6 → exactly DEPTH+1=5 accepted, in_ready low with count=4, outputs stable. Release div_ready → pairs emerge in order, one per cycle.
- Simultaneous push/pop at full: hold full, then one cycle with div_ready=1 and in_valid=1 → no push that cycle (in_ready was 0). Next cycle push accepted; count returns to 4.
- Reset mid-op: three pairs buffered, assert rst for one cycle → div_valid=0, in_ready=1 after rst deasserts, special_count=0, no stale pair ever emitted.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: constants, field extractors and the operand class enum.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam int          FP32_BIAS    = 127;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp32_class_t;

  function automatic logic fp32_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp32_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp32_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier. Denormals are flushed to ZERO.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]  x_i,
  output fp32_class_t  cls_o
);

  logic [7:0]  exp_w;
  logic [22:0] frac_w;

  assign exp_w  = fp32_exp(x_i);
  assign frac_w = fp32_frac(x_i);

  // Zero exponent covers true zeros and denormals; max exponent splits inf/NaN.
  always_comb begin
    cls_o = NORMAL;
    if (exp_w == 8'h00) begin
      cls_o = ZERO;
    end else if (exp_w == FP32_EXP_MAX) begin
      cls_o = (frac_w == 23'h0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_div_operand_stage.sv
// Operand issue stage for the FP32 divider: FIFO buffer, special-case
// classification of the FIFO head, and one registered operand pair.
//
// Handshake: a transfer happens on an edge where valid && ready. Upstream
// holds in_a/in_b while in_valid && !in_ready; the output pair (div_*) holds
// stable while div_valid && !div_ready. in_ready depends on registered count
// only, never on div_ready.
module fp_div_operand_stage
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             div_valid,
  input  logic             div_ready,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_special,
  output logic [31:0]      div_special_result,
  output logic [CNT_W-1:0] special_count
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem_a_q [DEPTH];
  logic [31:0]      mem_b_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             div_valid_q, div_valid_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             div_special_q, div_special_d;
  logic [31:0]      div_result_q, div_result_d;
  logic [CNT_W-1:0] special_cnt_q, special_cnt_d;

  logic             push, pop, out_hs;
  logic [31:0]      head_a, head_b;
  fp32_class_t      cls_a, cls_b;
  logic             head_special;
  logic [31:0]      head_result;
  logic             res_sign;

  assign in_ready = !rst && (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!div_valid_q || div_ready);
  assign out_hs   = div_valid_q && div_ready;

  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];
  assign res_sign = fp32_sign(head_a) ^ fp32_sign(head_b);

  fp32_classify u_cls_a (.x_i(head_a), .cls_o(cls_a));
  fp32_classify u_cls_b (.x_i(head_b), .cls_o(cls_b));

  // Special-case selection on the FIFO head, first matching rule wins.
  always_comb begin
    head_special = 1'b1;
    head_result  = 32'h0;
    if (cls_a == NAN || cls_b == NAN) begin
      head_result = FP32_QNAN;
    end else if ((cls_a == INF && cls_b == INF) || (cls_a == ZERO && cls_b == ZERO)) begin
      head_result = FP32_QNAN;
    end else if (cls_a == INF || cls_b == ZERO) begin
      head_result = {res_sign, FP32_EXP_MAX, 23'h0};
    end else if (cls_a == ZERO || cls_b == INF) begin
      head_result = {res_sign, 31'h0};
    end else begin
      head_special = 1'b0;
    end
  end

  // Next-state for FIFO pointers, occupancy, output register and counter.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    div_valid_d   = div_valid_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    div_special_d = div_special_q;
    div_result_d  = div_result_q;
    special_cnt_d = special_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      div_valid_d   = 1'b1;
      div_a_d       = head_a;
      div_b_d       = head_b;
      div_special_d = head_special;
      div_result_d  = head_result;
    end else if (out_hs) begin
      div_valid_d   = 1'b0;
    end

    if (out_hs && div_special_q && (special_cnt_q != '1)) begin
      special_cnt_d = special_cnt_q + 1'b1;
    end
  end

  // Control and output state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      div_valid_q   <= 1'b0;
      div_a_q       <= 32'h0;
      div_b_q       <= 32'h0;
      div_special_q <= 1'b0;
      div_result_q  <= 32'h0;
      special_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      div_valid_q   <= div_valid_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_special_q <= div_special_d;
      div_result_q  <= div_result_d;
      special_cnt_q <= special_cnt_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  assign div_valid          = div_valid_q;
  assign div_a              = div_a_q;
  assign div_b              = div_b_q;
  assign div_special        = div_special_q;
  assign div_special_result = div_result_q;
  assign special_count      = special_cnt_q;

endmodule

// File: tb/tb_fp_div_operand_stage.sv
// Self-checking bench for fp_div_operand_stage: directed special-case vectors,
// backpressure/full behaviour, mid-operation reset and randomized traffic.
module tb_fp_div_operand_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic             div_valid;
  logic             div_ready;
  logic [31:0]      div_a, div_b;
  logic             div_special;
  logic [31:0]      div_special_result;
  logic [CNT_W-1:0] special_count;

  fp_div_operand_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_a               (in_a),
    .in_b               (in_b),
    .div_valid          (div_valid),
    .div_ready          (div_ready),
    .div_a              (div_a),
    .div_b              (div_b),
    .div_special        (div_special),
    .div_special_result (div_special_result),
    .special_count      (special_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: IEEE division special cases with flush-to-zero inputs.
  // Returns {special, result}.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic s;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'd255) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'd255) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'd255) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'd255) && (b[22:0] != 23'd0);
    s      = a[31] ^ b[31];
    if (a_nan || b_nan)                        return {1'b1, 32'h7FC00000};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {1'b1, 32'h7FC00000};
    if (a_inf || b_zero)                       return {1'b1, s, 8'hFF, 23'h0};
    if (a_zero || b_inf)                       return {1'b1, s, 31'h0};
    return {1'b0, 32'h0};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 6);
    e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'd0; f = 23'd0; end
      2: begin e = 8'hFF; f = 23'd0; end
      3: e = 8'hFF;
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [63:0]      exp_q[$];
  logic [CNT_W-1:0] model_cnt = '0;
  bit               prev_hold = 1'b0;
  logic [31:0]      prev_a, prev_b, prev_res;
  logic             prev_sp;

  always @(negedge clk) begin
    logic [63:0] e;
    logic [32:0] r;
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
      prev_hold = 1'b0;
    end else begin
      chk("special_count", 64'(special_count), 64'(model_cnt));
      if (prev_hold) begin
        chk("hold_valid",  64'(div_valid), 64'd1);
        chk("hold_a",      64'(div_a), 64'(prev_a));
        chk("hold_b",      64'(div_b), 64'(prev_b));
        chk("hold_sp",     64'(div_special), 64'(prev_sp));
        chk("hold_result", 64'(div_special_result), 64'(prev_res));
      end
      if (div_valid && div_ready) begin
        chk("out_available", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          r = ref_div(e[63:32], e[31:0]);
          chk("out_a",       64'(div_a), 64'(e[63:32]));
          chk("out_b",       64'(div_b), 64'(e[31:0]));
          chk("out_special", 64'(div_special), 64'(r[32]));
          chk("out_result",  64'(div_special_result), 64'(r[31:0]));
          if (r[32] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_a, in_b});
      prev_hold = div_valid && !div_ready;
      prev_a    = div_a;
      prev_b    = div_b;
      prev_sp   = div_special;
      prev_res  = div_special_result;
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one pair with div_ready=1, wait for it at the output, compare to constants.
  task automatic send_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic sp, input logic [31:0] res, input bit chk_lat);
    bit acc;
    int lat;
    acc = 1'b0;
    lat = 0;
    div_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 64'(acc), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (div_valid) break;
    end
    chk({tag, "_valid"},   64'(div_valid), 64'd1);
    if (chk_lat) chk({tag, "_latency"}, 64'(lat), 64'd2);
    chk({tag, "_a"},       64'(div_a), 64'(a));
    chk({tag, "_b"},       64'(div_b), 64'(b));
    chk({tag, "_special"}, 64'(div_special), 64'(sp));
    chk({tag, "_result"},  64'(div_special_result), 64'(res));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, acc, run;
    bit acc_now;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; div_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div_valid",   64'(div_valid), 64'd0);
    chk("rst_div_a",       64'(div_a), 64'd0);
    chk("rst_div_b",       64'(div_b), 64'd0);
    chk("rst_div_special", 64'(div_special), 64'd0);
    chk("rst_result",      64'(div_special_result), 64'd0);
    chk("rst_count",       64'(special_count), 64'd0);
    chk("rst_in_ready_lo", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed special-case vectors.
    send_expect("normal",   32'h40C00000, 32'h40000000, 1'b0, 32'h00000000, 1'b1);
    chk("sc_normal", 64'(special_count), 64'd0);
    send_expect("pos_div0", 32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 1'b0);
    send_expect("neg_div0", 32'hBF800000, 32'h00000000, 1'b1, 32'hFF800000, 1'b0);
    @(negedge clk);
    chk("sc_after_div0", 64'(special_count), 64'd2);
    @(posedge clk); #1;
    send_expect("zero_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b0);
    send_expect("inf_inf",   32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b0);
    send_expect("nan_a",     32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b0);
    send_expect("denorm",    32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
    send_expect("inf_b",     32'hC0000000, 32'h7F800000, 1'b1, 32'h80000000, 1'b0);

    // Backpressure: offer six pairs with div_ready low.
    div_ready = 1'b0;
    k = 1; acc = 0;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000 + 32'(k);
    repeat (10) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) acc++;
      @(posedge clk); #1;
      if (acc_now && k < 6) begin
        k++;
        in_b = 32'h3F800000 + 32'(k);
      end
    end
    chk("bp_accepted", 64'(acc), 64'(DEPTH + 1));
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;

    // Full with pair 6 pending: one pop cycle, no push that cycle, push next.
    div_ready = 1'b1;
    @(negedge clk);
    chk("full_no_push", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    div_ready = 1'b0;
    @(negedge clk);
    chk("refill_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;

    // Drain: five pairs back to back.
    div_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_valid) run++;
      else if (run > 0) break;
    end
    chk("drain_run", 64'(run), 64'(DEPTH + 1));
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Reset mid-operation with three buffered special pairs.
    div_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h3F800000 + 32'(i); in_b = 32'h00000000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    div_ready = 1'b1;
    @(negedge clk);
    chk("midrst_div_valid", 64'(div_valid), 64'd0);
    chk("midrst_in_ready1", 64'(in_ready), 64'd1);
    chk("midrst_count",     64'(special_count), 64'd0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(div_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_a = rand_fp();
          in_b = rand_fp();
        end else begin
          in_valid = 1'b0;
        end
      end
      div_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    div_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_idle",    64'(div_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
